tlb_entry_queue: RTL and testbench

TLB_ENTRY_QUEUE -- requirements
Module: tlb_entry_queue

---
 rtl/tlb_pkg.sv | 32 +++
 rtl/tlb_entry_queue.sv | 111 +++++++++++
 tb/tb_tlb_entry_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared types and helpers for TLB refill entry queues.
// Holds the permission/fault flag bundle, the entry layout and the fault reduction.
// No logic of its own; imported by the queue and its neighbours.
package tlb_pkg;

  localparam int PPN_W_DEFAULT = 21;
  localparam int DEPTH_DEFAULT = 2;

  // Seven permission/fault flags carried alongside every page number.
  typedef struct packed {
    logic u;
    logic ae_ptw;
    logic ae_final;
    logic pf;
    logic gf;
    logic sx;
    logic px;
  } tlb_flags_t;

  // Entry at the default page-number width. Modules with a non-default PPN_W
  // build the same layout locally as { logic [PPN_W-1:0] ppn; tlb_flags_t flags; }.
  typedef struct packed {
    logic [PPN_W_DEFAULT-1:0] ppn;
    tlb_flags_t               flags;
  } tlb_entry_t;

  // An entry is faulting if any access-exception, page-fault or guest-fault flag is set.
  function automatic logic tlb_fault(input tlb_flags_t f);
    return f.ae_ptw | f.ae_final | f.pf | f.gf;
  endfunction

endpackage

// File: rtl/tlb_entry_queue.sv
// FIFO of TLB entries (page number plus seven flags), DEPTH slots, strict order.
// Latency: one cycle from enqueue to visibility at deq; no bypass, no flow-through.
// Backpressure: enq_ready from count only (count<DEPTH); flush/reset drop everything.
module tlb_entry_queue
  import tlb_pkg::*;
#(
  parameter int PPN_W = PPN_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_flush,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [PPN_W-1:0]           io_enq_bits_ppn,
  input  logic                       io_enq_bits_u,
  input  logic                       io_enq_bits_ae_ptw,
  input  logic                       io_enq_bits_ae_final,
  input  logic                       io_enq_bits_pf,
  input  logic                       io_enq_bits_gf,
  input  logic                       io_enq_bits_sx,
  input  logic                       io_enq_bits_px,
  output logic                       io_deq_valid,
  input  logic                       io_deq_ready,
  output logic [PPN_W-1:0]           io_deq_bits_ppn,
  output logic                       io_deq_bits_u,
  output logic                       io_deq_bits_ae_ptw,
  output logic                       io_deq_bits_ae_final,
  output logic                       io_deq_bits_pf,
  output logic                       io_deq_bits_gf,
  output logic                       io_deq_bits_sx,
  output logic                       io_deq_bits_px,
  output logic                       io_deq_fault,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    tlb_flags_t       flags;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             enq_fire;
  logic             deq_fire;
  entry_t           enq_entry;
  entry_t           head;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign io_enq_ready = (count < CNT_W'(DEPTH));
  assign io_deq_valid = (count != '0);
  // Flush suppresses both handshakes; ready/valid themselves stay count-derived.
  assign enq_fire     = io_enq_valid & io_enq_ready & ~io_flush;
  assign deq_fire     = io_deq_valid & io_deq_ready & ~io_flush;

  assign enq_entry.ppn            = io_enq_bits_ppn;
  assign enq_entry.flags.u        = io_enq_bits_u;
  assign enq_entry.flags.ae_ptw   = io_enq_bits_ae_ptw;
  assign enq_entry.flags.ae_final = io_enq_bits_ae_final;
  assign enq_entry.flags.pf       = io_enq_bits_pf;
  assign enq_entry.flags.gf       = io_enq_bits_gf;
  assign enq_entry.flags.sx       = io_enq_bits_sx;
  assign enq_entry.flags.px       = io_enq_bits_px;

  // Storage is never reset: a write during reset lands in a slot the reset pointers ignore.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  // Pointer and occupancy tracking; reset outranks flush, flush outranks handshakes.
  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= next_ptr(wr_ptr);
      if (deq_fire) rd_ptr <= next_ptr(rd_ptr);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head                 = mem[rd_ptr];
  assign io_deq_bits_ppn      = head.ppn;
  assign io_deq_bits_u        = head.flags.u;
  assign io_deq_bits_ae_ptw   = head.flags.ae_ptw;
  assign io_deq_bits_ae_final = head.flags.ae_final;
  assign io_deq_bits_pf       = head.flags.pf;
  assign io_deq_bits_gf       = head.flags.gf;
  assign io_deq_bits_sx       = head.flags.sx;
  assign io_deq_bits_px       = head.flags.px;
  // Qualified by valid so stale storage never reports a fault.
  assign io_deq_fault         = io_deq_valid & tlb_fault(head.flags);
  assign io_count             = count;

endmodule

// File: tb/tb_tlb_entry_queue.sv
// Directed bench for tlb_entry_queue: DEPTH=2 instance for fill/drain, simultaneous,
// fault, flush and reset cases; DEPTH=3 instance for a wrapping 10-entry stream.
// Flag vectors are packed {u,ae_ptw,ae_final,pf,gf,sx,px}, MSB first.
module tb_tlb_entry_queue;

  localparam int PW = 21;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int sent     = 0;
  int got      = 0;

  // DEPTH=2 instance signals
  logic          a_reset, a_flush, a_enq_valid, a_enq_ready, a_deq_valid, a_deq_ready, a_fault;
  logic [PW-1:0] a_enq_ppn, a_deq_ppn;
  logic [6:0]    a_in_f, a_out_f;
  logic [1:0]    a_count;

  // DEPTH=3 instance signals
  logic          b_reset, b_flush, b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready, b_fault;
  logic [PW-1:0] b_enq_ppn, b_deq_ppn;
  logic [6:0]    b_in_f, b_out_f;
  logic [1:0]    b_count;

  tlb_entry_queue #(.PPN_W(PW), .DEPTH(2)) dut_a (
    .clock(clock), .reset(a_reset), .io_flush(a_flush),
    .io_enq_valid(a_enq_valid), .io_enq_ready(a_enq_ready), .io_enq_bits_ppn(a_enq_ppn),
    .io_enq_bits_u(a_in_f[6]), .io_enq_bits_ae_ptw(a_in_f[5]), .io_enq_bits_ae_final(a_in_f[4]),
    .io_enq_bits_pf(a_in_f[3]), .io_enq_bits_gf(a_in_f[2]), .io_enq_bits_sx(a_in_f[1]),
    .io_enq_bits_px(a_in_f[0]),
    .io_deq_valid(a_deq_valid), .io_deq_ready(a_deq_ready), .io_deq_bits_ppn(a_deq_ppn),
    .io_deq_bits_u(a_out_f[6]), .io_deq_bits_ae_ptw(a_out_f[5]), .io_deq_bits_ae_final(a_out_f[4]),
    .io_deq_bits_pf(a_out_f[3]), .io_deq_bits_gf(a_out_f[2]), .io_deq_bits_sx(a_out_f[1]),
    .io_deq_bits_px(a_out_f[0]),
    .io_deq_fault(a_fault), .io_count(a_count)
  );

  tlb_entry_queue #(.PPN_W(PW), .DEPTH(3)) dut_b (
    .clock(clock), .reset(b_reset), .io_flush(b_flush),
    .io_enq_valid(b_enq_valid), .io_enq_ready(b_enq_ready), .io_enq_bits_ppn(b_enq_ppn),
    .io_enq_bits_u(b_in_f[6]), .io_enq_bits_ae_ptw(b_in_f[5]), .io_enq_bits_ae_final(b_in_f[4]),
    .io_enq_bits_pf(b_in_f[3]), .io_enq_bits_gf(b_in_f[2]), .io_enq_bits_sx(b_in_f[1]),
    .io_enq_bits_px(b_in_f[0]),
    .io_deq_valid(b_deq_valid), .io_deq_ready(b_deq_ready), .io_deq_bits_ppn(b_deq_ppn),
    .io_deq_bits_u(b_out_f[6]), .io_deq_bits_ae_ptw(b_out_f[5]), .io_deq_bits_ae_final(b_out_f[4]),
    .io_deq_bits_pf(b_out_f[3]), .io_deq_bits_gf(b_out_f[2]), .io_deq_bits_sx(b_out_f[1]),
    .io_deq_bits_px(b_out_f[0]),
    .io_deq_fault(b_fault), .io_count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge so outputs are settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_push(input logic [PW-1:0] ppn, input logic [6:0] f);
    a_enq_valid = 1'b1;
    a_enq_ppn   = ppn;
    a_in_f      = f;
    tick();
    a_enq_valid = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_flush = 1'b0; a_enq_valid = 1'b0; a_deq_ready = 1'b0;
    a_enq_ppn = '0; a_in_f = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_enq_valid = 1'b0; b_deq_ready = 1'b0;
    b_enq_ppn = '0; b_in_f = '0;
    tick();
    tick();
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Reset state
    chk("rst_count", a_count, 0);
    chk("rst_enq_ready", a_enq_ready, 1);
    chk("rst_deq_valid", a_deq_valid, 0);
    chk("rst_fault", a_fault, 0);

    // No flow-through: offering an entry to an empty queue does not raise deq_valid
    a_enq_valid = 1'b1; a_enq_ppn = 21'h00001; a_in_f = 7'h00;
    #1;
    chk("no_flowthrough", a_deq_valid, 0);
    tick();
    chk("fill1_valid", a_deq_valid, 1);
    chk("fill1_count", a_count, 1);
    a_enq_ppn = 21'h00002;
    tick();
    a_enq_valid = 1'b0;
    chk("fill2_ready", a_enq_ready, 0);
    chk("fill2_count", a_count, 2);
    chk("fill2_head", a_deq_ppn, 21'h00001);
    // No full-bypass: deq_ready does not reopen enq_ready
    a_deq_ready = 1'b1;
    #1;
    chk("no_bypass", a_enq_ready, 0);
    tick();
    chk("drain1_head", a_deq_ppn, 21'h00002);
    chk("drain1_count", a_count, 1);
    tick();
    chk("drain2_count", a_count, 0);
    chk("drain2_valid", a_deq_valid, 0);
    a_deq_ready = 1'b0;

    // Simultaneous enqueue and dequeue at count=1
    a_push(21'h0000A, 7'h00);
    a_enq_valid = 1'b1; a_enq_ppn = 21'h0000B; a_deq_ready = 1'b1;
    tick();
    a_enq_valid = 1'b0;
    chk("simul_count", a_count, 1);
    chk("simul_head", a_deq_ppn, 21'h0000B);
    tick();
    a_deq_ready = 1'b0;
    chk("simul_drain", a_count, 0);

    // Fault reduction: pf alone faults, sx alone does not
    a_push(21'h00003, 7'b0001000);
    chk("fault_pf", a_fault, 1);
    chk("fault_pf_flags", a_out_f, 7'b0001000);
    a_deq_ready = 1'b1; tick(); a_deq_ready = 1'b0;
    chk("fault_empty", a_fault, 0);
    a_push(21'h00004, 7'b0000010);
    chk("fault_sx", a_fault, 0);
    chk("fault_sx_flags", a_out_f, 7'b0000010);
    a_deq_ready = 1'b1; tick(); a_deq_ready = 1'b0;

    // Flush with a concurrent enqueue and dequeue offer
    a_push(21'h00011, 7'h00);
    a_push(21'h00012, 7'h00);
    a_flush = 1'b1; a_enq_valid = 1'b1; a_enq_ppn = 21'h00013; a_deq_ready = 1'b1;
    #1;
    chk("flush_cyc_ready", a_enq_ready, 0);
    chk("flush_cyc_valid", a_deq_valid, 1);
    tick();
    a_flush = 1'b0; a_enq_valid = 1'b0; a_deq_ready = 1'b0;
    chk("flush_count", a_count, 0);
    chk("flush_valid", a_deq_valid, 0);
    a_push(21'h00014, 7'h00);
    chk("flush_after_head", a_deq_ppn, 21'h00014);
    chk("flush_after_count", a_count, 1);
    a_deq_ready = 1'b1; tick(); a_deq_ready = 1'b0;

    // Reset mid-operation, with an enqueue offered during reset
    a_push(21'h00021, 7'h00);
    a_push(21'h00022, 7'h00);
    a_reset = 1'b1; a_enq_valid = 1'b1; a_enq_ppn = 21'h00023;
    tick();
    a_reset = 1'b0; a_enq_valid = 1'b0;
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_ready", a_enq_ready, 1);
    chk("mid_rst_valid", a_deq_valid, 0);
    a_push(21'h1FFFFF, 7'h7F);
    chk("post_rst_ppn", a_deq_ppn, 21'h1FFFFF);
    chk("post_rst_flags", a_out_f, 7'h7F);
    chk("post_rst_fault", a_fault, 1);

    // DEPTH=3 wrapping stream with random consumer stalls
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      b_enq_valid = (sent < 10);
      b_enq_ppn   = PW'(sent + 1);
      b_in_f      = 7'(sent + 1);
      b_deq_ready = 1'($urandom_range(0, 1));
      #1;
      if (b_deq_valid && b_deq_ready) begin
        chk("wrap_ppn", b_deq_ppn, got + 1);
        chk("wrap_flags", b_out_f, 7'(got + 1));
        got++;
      end
      if (b_enq_valid && b_enq_ready) sent++;
      tick();
    end
    b_enq_valid = 1'b0;
    b_deq_ready = 1'b0;
    chk("wrap_received", got, 10);
    chk("wrap_sent", sent, 10);
    chk("wrap_empty", b_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
